// File: rtl/ap_peak_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ap_peak_meter_if
//  Description : Sample/control inputs and display outputs of the peak meter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ap_peak_meter_if;
  logic        tick;
  logic [15:0] ap;
  logic        clip_clr;
  logic [4:0]  level_out;
  logic [4:0]  peak_out;
  logic [15:0] bar;
  logic        clip_out;
  logic        clip_sticky;

  // Upstream side: supplies samples and control, observes the meter.
  modport master (
    output tick, ap, clip_clr,
    input  level_out, peak_out, bar, clip_out, clip_sticky
  );

  // Meter side.
  modport slave (
    input  tick, ap, clip_clr,
    output level_out, peak_out, bar, clip_out, clip_sticky
  );
endinterface
`default_nettype wire

// File: rtl/ap_peak_meter.sv
`default_nettype none
// ============================================================================
//  Module      : ap_peak_meter
//  Description : Thermometer-code level meter with peak hold/decay, display
//                bar and stretched/sticky clip indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module ap_peak_meter #(
  parameter int HOLD_TICKS  = 32,
  parameter int DECAY_TICKS = 4,
  parameter int CLIP_TICKS  = 64
) (
  input  wire             clock,
  input  wire             rst,
  ap_peak_meter_if.slave  m
);

  localparam logic [7:0] C_HOLD_INIT  = 8'(HOLD_TICKS - 1);
  localparam logic [7:0] C_DECAY_INIT = 8'(DECAY_TICKS - 1);
  localparam logic [7:0] C_CLIP_INIT  = 8'(CLIP_TICKS - 1);
  localparam logic [4:0] C_FULL_SCALE = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DECAY = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  level_q;
  logic [4:0]  peak_q;
  logic [7:0]  hold_cnt_q;
  logic [7:0]  decay_cnt_q;
  logic [7:0]  clip_cnt_q;
  logic        clip_q;
  logic        sticky_q;
  logic [15:0] bar_q;
  logic [15:0] bar_d;
  logic [4:0]  lvl_w;
  logic        run_w;

  // Count the unbroken run of ones from bit 0; anything past the first zero is a bubble.
  always_comb begin
    lvl_w = 5'd0;
    run_w = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (run_w && m.ap[i]) begin
        lvl_w = lvl_w + 5'd1;
      end else begin
        run_w = 1'b0;
      end
    end
  end

  // Bar image: filled segments below the level plus a single dot at the peak.
  always_comb begin
    bar_d = '0;
    for (int i = 0; i < 16; i++) begin
      bar_d[i] = (5'(i) < level_q) || ((peak_q != 5'd0) && (5'(i) == peak_q - 5'd1));
    end
  end

  // Level, peak hold/decay FSM, clip stretch and sticky flag; all advance only on tick.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      level_q     <= 5'd0;
      peak_q      <= 5'd0;
      hold_cnt_q  <= 8'd0;
      decay_cnt_q <= 8'd0;
      clip_cnt_q  <= 8'd0;
      clip_q      <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      if (m.tick) begin
        level_q <= lvl_w;

        // A new level at or above the peak (re)captures it and restarts the hold.
        if ((lvl_w >= peak_q) && (lvl_w != 5'd0)) begin
          peak_q     <= lvl_w;
          hold_cnt_q <= C_HOLD_INIT;
          state_q    <= ST_HOLD;
        end else begin
          case (state_q)
            ST_HOLD: begin
              if (hold_cnt_q != 8'd0) begin
                hold_cnt_q <= hold_cnt_q - 8'd1;
              end else begin
                state_q     <= ST_DECAY;
                decay_cnt_q <= C_DECAY_INIT;
              end
            end
            ST_DECAY: begin
              if (decay_cnt_q != 8'd0) begin
                decay_cnt_q <= decay_cnt_q - 8'd1;
              end else begin
                peak_q      <= peak_q - 5'd1;
                decay_cnt_q <= C_DECAY_INIT;
                if (peak_q == 5'd1) begin
                  state_q <= ST_IDLE;
                end
              end
            end
            default: begin
              state_q <= ST_IDLE;
              peak_q  <= 5'd0;
            end
          endcase
        end

        // Clip stretch restarts on every full-scale tick and runs down otherwise.
        if (lvl_w == C_FULL_SCALE) begin
          clip_q     <= 1'b1;
          clip_cnt_q <= C_CLIP_INIT;
        end else if (clip_cnt_q != 8'd0) begin
          clip_cnt_q <= clip_cnt_q - 8'd1;
        end else begin
          clip_q <= 1'b0;
        end
      end

      // Setting wins over a simultaneous clear so a clip is never lost.
      if (m.tick && (lvl_w == C_FULL_SCALE)) begin
        sticky_q <= 1'b1;
      end else if (m.clip_clr) begin
        sticky_q <= 1'b0;
      end
    end
  end

  // Bar is refreshed every clock from the registered level/peak, one cycle behind them.
  always_ff @(posedge clock) begin
    if (rst) begin
      bar_q <= 16'd0;
    end else begin
      bar_q <= bar_d;
    end
  end

  assign m.level_out   = level_q;
  assign m.peak_out    = peak_q;
  assign m.bar         = bar_q;
  assign m.clip_out    = clip_q;
  assign m.clip_sticky = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_ap_peak_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ap_peak_meter
//  Description : Directed self-checking bench for ap_peak_meter (defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ap_peak_meter;

  logic clock;
  logic rst;
  int   errors;
  int   checks;

  ap_peak_meter_if io ();

  ap_peak_meter #(
    .HOLD_TICKS  (32),
    .DECAY_TICKS (4),
    .CLIP_TICKS  (64)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .m     (io.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with tick high carrying the given code; returns #1 after the edge.
  task automatic do_tick(input logic [15:0] v);
    io.tick = 1'b1;
    io.ap   = v;
    @(posedge clock);
    #1;
    io.tick = 1'b0;
  endtask

  task automatic idle_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_clk();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] hold_model(input int n);
    if (n < 32) return 5'd12;
    return 5'(12 - (n - 32) / 4);
  endfunction

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    io.tick     = 1'b0;
    io.ap       = 16'h0000;
    io.clip_clr = 1'b0;
    idle_clk();
    idle_clk();
    rst = 1'b0;

    // Reset state
    chk("rst_level", io.level_out, 0);
    chk("rst_peak", io.peak_out, 0);
    chk("rst_bar", io.bar, 0);
    chk("rst_clip", io.clip_out, 0);
    chk("rst_sticky", io.clip_sticky, 0);

    // Decode sweep: every thermometer code, then two bubbled codes
    for (int k = 0; k <= 16; k++) begin
      logic [31:0] code;
      code = (32'h1 << k) - 32'h1;
      do_tick(code[15:0]);
      chk($sformatf("decode_%0d", k), io.level_out, k);
    end
    do_tick(16'h00F7);
    chk("decode_00F7", io.level_out, 3);
    do_tick(16'h8001);
    chk("decode_8001", io.level_out, 1);

    // Bar fill and peak dot
    do_reset();
    do_tick(16'h003F);
    idle_clk();
    chk("bar_fill6", io.bar, 16'h003F);
    do_tick(16'h0007);
    idle_clk();
    chk("bar_lvl3_pk6", io.bar, 16'h0027);
    chk("peak_pk6", io.peak_out, 6);

    // Hold then decay from 12
    do_reset();
    do_tick(16'h0FFF);
    chk("hd_peak0", io.peak_out, 12);
    for (int n = 1; n <= 80; n++) begin
      do_tick(16'h0000);
      chk($sformatf("hd_peak_%0d", n), io.peak_out, hold_model(n));
      if (n == 40) begin
        idle_clk();
        chk("hd_bar_dot10", io.bar, 16'h0200);
      end
    end
    idle_clk();
    chk("hd_bar_empty", io.bar, 0);
    do_tick(16'h0001);
    chk("hd_from_idle", io.peak_out, 1);

    // Retrigger while decaying at 12
    do_reset();
    do_tick(16'h0FFF);
    for (int n = 1; n <= 33; n++) do_tick(16'h0000);
    chk("rt_decaying12", io.peak_out, 12);
    do_tick(16'h0FFF);
    for (int n = 1; n <= 35; n++) do_tick(16'h0000);
    chk("rt_hold_restart35", io.peak_out, 12);
    do_tick(16'h0000);
    chk("rt_hold_restart36", io.peak_out, 11);
    do_tick(16'h3FFF);
    chk("rt_peak14", io.peak_out, 14);
    chk("rt_level14", io.level_out, 14);

    // Clip stretch and sticky flag
    do_reset();
    do_tick(16'hFFFF);
    chk("clip_set", io.clip_out, 1);
    chk("sticky_set", io.clip_sticky, 1);
    for (int n = 1; n <= 64; n++) begin
      do_tick(16'h0000);
      chk($sformatf("clip_after_%0d", n), io.clip_out, (n < 64) ? 1 : 0);
    end
    chk("sticky_held", io.clip_sticky, 1);
    io.clip_clr = 1'b1;
    idle_clk();
    io.clip_clr = 1'b0;
    chk("sticky_cleared", io.clip_sticky, 0);
    io.clip_clr = 1'b1;
    do_tick(16'hFFFF);
    io.clip_clr = 1'b0;
    chk("sticky_set_wins", io.clip_sticky, 1);

    // No tick: inputs move, state must not
    do_reset();
    do_tick(16'h0FFF);
    io.ap = 16'hFFFF;
    for (int n = 0; n < 10; n++) begin
      idle_clk();
      io.ap = io.ap ^ 16'h5A5A;
    end
    chk("nt_level", io.level_out, 12);
    chk("nt_peak", io.peak_out, 12);
    chk("nt_clip", io.clip_out, 0);
    chk("nt_sticky", io.clip_sticky, 0);
    for (int n = 1; n <= 35; n++) do_tick(16'h0000);
    chk("nt_hold35", io.peak_out, 12);
    do_tick(16'h0000);
    chk("nt_hold36", io.peak_out, 11);

    // Reset during HOLD
    do_reset();
    do_tick(16'hFFFF);
    do_tick(16'h001F);
    idle_clk();
    rst = 1'b1;
    io.tick = 1'b1;
    io.ap = 16'hFFFF;
    io.clip_clr = 1'b0;
    idle_clk();
    rst = 1'b0;
    io.tick = 1'b0;
    chk("mr_level", io.level_out, 0);
    chk("mr_peak", io.peak_out, 0);
    chk("mr_bar", io.bar, 0);
    chk("mr_clip", io.clip_out, 0);
    chk("mr_sticky", io.clip_sticky, 0);
    do_tick(16'h0007);
    chk("mr_after_peak", io.peak_out, 3);
    chk("mr_after_level", io.level_out, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ap_peak_meter.md
AP_PEAK_METER -- requirements
Module: ap_peak_meter

Interface
REQ-001 Parameter HOLD_TICKS, default 32: ticks the peak is held before decay begins; legal range 1..255.
REQ-002 Parameter DECAY_TICKS, default 4: ticks per one-step peak decrement during decay; legal range 1..255.
REQ-003 Parameter CLIP_TICKS, default 64: stretch length of clip_out, in ticks; legal range 1..255.
REQ-004 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port tick, input, 1: sample strobe; ap is consumed only on clock edges where tick=1.
REQ-007 Port ap, input, 16: thermometer amplitude code from the upstream sqrt-threshold stage; bit i set means amplitude exceeds threshold i.
REQ-008 Port clip_clr, input, 1: clears clip_sticky.
REQ-009 Port level_out, output, 5: current level, 0..16.
REQ-010 Port peak_out, output, 5: held/decaying peak level, 0..16.
REQ-011 Port bar, output, 16: display bar, level fill plus peak dot.
REQ-012 Port clip_out, output, 1: stretched clip indication.
REQ-013 Port clip_sticky, output, 1: latched clip flag.

Function
REQ-014 Level decode: lvl SHALL be the count of contiguous ones starting at ap[0] (ap=16'h0000 -> 0, 16'h00FF -> 8, 16'hFFFF -> 16); bits above the first zero are ignored (bubble suppression, e.g. 16'h00F7 -> 3).
REQ-015 On a tick edge, level_out SHALL load lvl; without tick, level_out, peak_out, and all counters SHALL hold.
REQ-016 Peak FSM states: IDLE (peak=0), HOLD, DECAY; evaluated only on tick edges, using the combinational lvl of that edge.
REQ-017 Any state, lvl >= peak_out and lvl > 0: peak_out <= lvl, hold_cnt <= HOLD_TICKS-1, next state HOLD; equal-level input therefore restarts the hold.
REQ-018 HOLD, lvl < peak_out: hold_cnt != 0 -> decrement it; hold_cnt == 0 -> go to DECAY, decay_cnt <= DECAY_TICKS-1, peak unchanged.
REQ-019 DECAY, lvl < peak_out: decay_cnt != 0 -> decrement it; decay_cnt == 0 -> peak_out <= peak_out-1, decay_cnt <= DECAY_TICKS-1; if the new peak is 0, go to IDLE.
REQ-020 Invariant: peak_out >= level_out after every tick edge; peak_out never wraps below 0.
REQ-021 IDLE with lvl = 0: remain in IDLE, peak_out = 0.
REQ-022 bar SHALL be registered every clock from the current level_out/peak_out (one-cycle lag): bit i = (i < level_out) OR (peak_out != 0 AND i == peak_out-1).
REQ-023 Clip: a tick with lvl == 16 SHALL set clip_out=1 and clip_cnt <= CLIP_TICKS-1 at that edge.
REQ-024 On a tick with lvl < 16: if clip_cnt != 0, decrement it; if clip_cnt == 0, clip_out <= 0; clip_out therefore stays high for exactly CLIP_TICKS ticks after the last clipping tick.
REQ-025 clip_sticky SHALL set on any tick with lvl == 16 and clear on clip_clr=1 (clip_clr acts without tick); a simultaneous set and clear SHALL leave it set.

Reset
REQ-026 rst=1 at a clock edge SHALL force level_out=0, peak_out=0, bar=0, clip_out=0, clip_sticky=0, all counters to 0, and state IDLE; this takes priority over tick and clip_clr.
REQ-027 Reset asserted mid-HOLD or mid-DECAY SHALL abandon the sequence; the first tick after release behaves as from IDLE.

Verification
REQ-028 Decode sweep: ap = each of the 17 valid thermometer codes plus 16'h00F7 and 16'h8001 with tick -> level_out = 0..16, then 3, then 1.
REQ-029 Hold/decay, defaults: one tick with ap=16'h0FFF (12), then ticks with ap=0 -> peak_out=12 for 32 ticks, then decrements every 4th tick, reaching 0 and IDLE after 32+48 ticks; bar shows a single dot at bit peak-1.
REQ-030 Retrigger: peak=12 decaying, tick with lvl=12 -> HOLD restarts with a full 32-tick hold; tick with lvl=14 -> peak_out=14 immediately.
REQ-031 Clip: one tick with ap=16'hFFFF, then ticks with ap=0 -> clip_out high for exactly 64 ticks; clip_sticky high until a clip_clr pulse; clip_clr issued on the same edge as a clipping tick -> clip_sticky stays 1.
REQ-032 No tick: ap changes while tick=0 -> no output or counter change; rst pulsed during HOLD -> all outputs 0 on the next edge.
